// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter
//   Round-robin arbiter guarding a single shared storage register. One
//   requester at a time owns the register and may write it once per cycle,
//   for at most MAXHOLD writes per grant. Every handover passes through one
//   IDLE cycle with no grant.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no owner; pick the next requester round-robin from last+1
//   GRANT | owner holds the register; writes while req[owner] stays high
//
// Ports
//   clk      in   clock, all state updates on the rising edge
//   rst      in   synchronous active-high reset
//   req      in   [NREQ]        per-requester access request
//   wdata    in   [NREQ*WIDTH]  write data, slice i*WIDTH +: WIDTH per requester
//   gnt      out  [NREQ]        one-hot-or-zero grant
//   owner    out  [log2 NREQ]   current or last granted requester
//   q        out  [WIDTH]       shared register contents
//   q_valid  out                one-cycle pulse marking a q update
//   busy     out                high while in GRANT

module reg_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int MAXHOLD = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     wdata,
    output logic [NREQ-1:0]           gnt,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic [WIDTH-1:0]          q,
    output logic                      q_valid,
    output logic                      busy
);

    localparam int OW = $clog2(NREQ);
    localparam int HW = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [OW-1:0]     owner_r, owner_nxt;
    logic [OW-1:0]     last_r, last_nxt;
    logic [HW-1:0]     hold_cnt, hold_nxt;
    logic [WIDTH-1:0]  q_r, q_nxt;
    logic              qv_r, qv_nxt;

    logic [OW-1:0]     winner;
    logic              found;
    logic [OW-1:0]     idx_w;
    int                idx;

    // Round-robin search starting just above the last winner, wrapping.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        idx_w  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx   = (int'(last_r) + k) % NREQ;
            idx_w = OW'(idx);
            if (!found && req[idx_w]) begin
                found  = 1'b1;
                winner = idx_w;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner_r;
        last_nxt  = last_r;
        hold_nxt  = hold_cnt;
        q_nxt     = q_r;
        qv_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    owner_nxt = winner;
                    last_nxt  = winner;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (req[owner_r]) begin
                    q_nxt  = wdata[int'(owner_r)*WIDTH +: WIDTH];
                    qv_nxt = 1'b1;
                    // Last permitted write also releases the grant.
                    if (hold_cnt == HW'(MAXHOLD - 1)) begin
                        state_nxt = IDLE;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt  = hold_cnt + 1'b1;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner_r  <= '0;
            last_r   <= OW'(NREQ - 1);
            hold_cnt <= '0;
            q_r      <= '0;
            qv_r     <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner_r  <= owner_nxt;
            last_r   <= last_nxt;
            hold_cnt <= hold_nxt;
            q_r      <= q_nxt;
            qv_r     <= qv_nxt;
        end
    end

    // gnt is derived from state and owner so it can never be multi-hot.
    assign busy    = (state == GRANT);
    assign gnt     = busy ? (NREQ'(1) << owner_r) : '0;
    assign owner   = owner_r;
    assign q       = q_r;
    assign q_valid = qv_r;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb_reg_share_arbiter
//   Directed bench for reg_share_arbiter (NREQ=4, WIDTH=8, MAXHOLD=4).
//   Inputs change 1 time unit after the rising edge; outputs are read at the
//   same point, so each tick shows the result of the edge just taken.

module tb_reg_share_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int MAXHOLD = 4;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*WIDTH-1:0]  wdata;
    logic [NREQ-1:0]        gnt;
    logic [1:0]             owner;
    logic [WIDTH-1:0]       q;
    logic                   q_valid;
    logic                   busy;

    int checks   = 0;
    int failures = 0;

    logic             rst_d = 1'b1;
    logic [WIDTH-1:0] prev_q = '0;

    reg_share_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .MAXHOLD(MAXHOLD)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata),
        .gnt(gnt), .owner(owner), .q(q), .q_valid(q_valid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wd(input int i, input logic [WIDTH-1:0] v);
        wdata[i*WIDTH +: WIDTH] = v;
    endtask

    // Continuous invariants: one-hot-or-zero grant, q only moves with q_valid
    // (reset is the one legitimate silent clear).
    always @(posedge clk) rst_d <= rst;

    always @(negedge clk) begin
        if (rst_d === 1'b0) begin
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (q !== prev_q)
                chk("q_chg_needs_valid", 32'(q_valid), 32'd1);
        end
        prev_q <= q;
    end

    initial begin
        rst   = 1'b1;
        req   = '0;
        wdata = '0;
        tick();
        tick();
        chk("rst_gnt",   32'(gnt),     32'h0);
        chk("rst_owner", 32'(owner),   32'h0);
        chk("rst_q",     32'(q),       32'h0);
        chk("rst_qv",    32'(q_valid), 32'h0);
        chk("rst_busy",  32'(busy),    32'h0);
        rst = 1'b0;
        tick();
        chk("idle_gnt",  32'(gnt),     32'h0);
        chk("idle_busy", 32'(busy),    32'h0);

        // Single requester: gnt after 1 edge, first write after 2.
        req = 4'b0001;
        set_wd(0, 8'hA5);
        tick();
        chk("s1_gnt",   32'(gnt),     32'h1);
        chk("s1_busy",  32'(busy),    32'h1);
        chk("s1_owner", 32'(owner),   32'h0);
        chk("s1_qv0",   32'(q_valid), 32'h0);
        tick();
        chk("s1_q",     32'(q),       32'hA5);
        chk("s1_qv1",   32'(q_valid), 32'h1);
        req = 4'b0000;
        tick();
        chk("s1_rel_gnt", 32'(gnt),     32'h0);
        chk("s1_rel_qv",  32'(q_valid), 32'h0);
        chk("s1_rel_q",   32'(q),       32'hA5);

        // All requesting: 0,1,2,3,0, each exactly MAXHOLD writes plus bubble.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_wd(i, 8'(8'h11 * (i + 1)));
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            int o;
            o = g % NREQ;
            tick();
            chk("rr_gnt",   32'(gnt),     32'(1 << o));
            chk("rr_owner", 32'(owner),   32'(o));
            chk("rr_qv0",   32'(q_valid), 32'h0);
            for (int w = 0; w < MAXHOLD; w++) begin
                tick();
                chk("rr_q",  32'(q),       32'(8'h11 * (o + 1)));
                chk("rr_qv", 32'(q_valid), 32'h1);
                if (w < MAXHOLD - 1)
                    chk("rr_hold_gnt", 32'(gnt), 32'(1 << o));
                else
                    chk("rr_bubble_gnt", 32'(gnt), 32'h0);
            end
        end
        req = 4'b0000;
        tick();
        chk("rr_end_gnt", 32'(gnt),     32'h0);
        chk("rr_end_qv",  32'(q_valid), 32'h0);

        // Requester 2 drops after two writes; q holds afterwards.
        req = 4'b0100;
        tick();
        chk("s3_gnt", 32'(gnt), 32'h4);
        set_wd(2, 8'h5C);
        tick();
        chk("s3_q1",  32'(q),       32'h5C);
        chk("s3_qv1", 32'(q_valid), 32'h1);
        set_wd(2, 8'h6D);
        tick();
        chk("s3_q2",  32'(q),       32'h6D);
        chk("s3_qv2", 32'(q_valid), 32'h1);
        chk("s3_gnt2", 32'(gnt),    32'h4);
        req = 4'b0000;
        set_wd(2, 8'h77);
        tick();
        chk("s3_rel_gnt",   32'(gnt),     32'h0);
        chk("s3_rel_qv",    32'(q_valid), 32'h0);
        chk("s3_rel_q",     32'(q),       32'h6D);
        chk("s3_rel_busy",  32'(busy),    32'h0);
        tick();
        chk("s3_hold_q",     32'(q),     32'h6D);
        chk("s3_hold_owner", 32'(owner), 32'h2);

        // Requester 1 owns; requester 3 rises mid-grant and must wait.
        req = 4'b0010;
        set_wd(1, 8'h21);
        set_wd(3, 8'hEE);
        tick();
        chk("s4_gnt", 32'(gnt), 32'h2);
        tick();
        chk("s4_q1", 32'(q), 32'h21);
        req = 4'b1010;
        set_wd(1, 8'h22);
        tick();
        chk("s4_q2",   32'(q),   32'h22);
        chk("s4_gnt2", 32'(gnt), 32'h2);
        set_wd(1, 8'h23);
        tick();
        chk("s4_q3",   32'(q),   32'h23);
        set_wd(1, 8'h24);
        tick();
        chk("s4_q4",      32'(q),       32'h24);
        chk("s4_qv4",     32'(q_valid), 32'h1);
        chk("s4_bubble",  32'(gnt),     32'h0);
        tick();
        chk("s4_gnt3",  32'(gnt),     32'h8);
        chk("s4_q_hold", 32'(q),      32'h24);
        tick();
        chk("s4_q_r3",  32'(q),       32'hEE);
        req = 4'b0000;
        tick();
        chk("s4_end_gnt", 32'(gnt), 32'h0);

        // Reset in the third write cycle of a grant, then priority restarts at 0.
        req = 4'b0100;
        set_wd(2, 8'h99);
        tick();
        chk("s5_gnt", 32'(gnt), 32'h4);
        tick();
        chk("s5_q1", 32'(q), 32'h99);
        tick();
        chk("s5_q2", 32'(q), 32'h99);
        set_wd(2, 8'h3C);
        rst = 1'b1;
        tick();
        chk("s5_rst_q",    32'(q),       32'h0);
        chk("s5_rst_gnt",  32'(gnt),     32'h0);
        chk("s5_rst_qv",   32'(q_valid), 32'h0);
        chk("s5_rst_busy", 32'(busy),    32'h0);
        rst = 1'b0;
        req = 4'b1111;
        tick();
        chk("s5_first_gnt",   32'(gnt),   32'h1);
        chk("s5_first_owner", 32'(owner), 32'h0);
        tick();
        chk("s5_q0",  32'(q),       32'h11);
        chk("s5_qv0", 32'(q_valid), 32'h1);
        req = 4'b0000;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
